// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration-time helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an iteration count of n; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_wid(input int mcand_wid, input int mplier_wid);
    return mcand_wid + mplier_wid;
  endfunction

endpackage

// File: rtl/cla_n.sv
// Parametrised carry-lookahead adder; every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module cla_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_carry;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    logic c;
    logic prop;
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave one holding its old value (no latches).
    c          = 1'b0;
    prop       = 1'b0;
    w_carry    = '0;
    w_carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c    = w_g[i];
      prop = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c    = c | (prop & w_g[j]);
        prop = prop & w_p[j];
      end
      w_carry[i+1] = c | (prop & cin);
    end
  end

  assign sum  = w_p ^ w_carry[WIDTH-1:0];
  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, sign handled
// by multiplying magnitudes and negating the finished product.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter  int MULTICAND_WID  = 8,
  parameter  int MULTIPLIER_WID = 8,
  localparam int PROD_WID       = prod_wid(MULTICAND_WID, MULTIPLIER_WID)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MULTICAND_WID-1:0]  multicand,
  input  logic [MULTIPLIER_WID-1:0] multiplier,
  input  logic                      signed_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PROD_WID-1:0]       product
);

  localparam int                CNT_WID  = clog2(MULTIPLIER_WID);
  localparam logic [CNT_WID-1:0] LAST_CNT = CNT_WID'(MULTIPLIER_WID - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [MULTICAND_WID-1:0]  r_mcand;
  logic [MULTIPLIER_WID-1:0] r_mplier;
  // Bit 0 of the accumulator is only ever shifted out, so it is not stored.
  logic [PROD_WID-1:1]       r_acc;
  logic [PROD_WID-1:0]       r_product;
  logic [CNT_WID-1:0]        r_count;
  logic                      r_neg;

  logic                      w_accept;
  logic                      w_last;
  logic [MULTICAND_WID-1:0]  w_mcand_abs;
  logic [MULTIPLIER_WID-1:0] w_mplier_abs;
  logic [MULTICAND_WID-1:0]  w_addend;
  logic [MULTICAND_WID-1:0]  w_sum;
  logic                      w_cout;
  logic [PROD_WID-1:0]       w_acc_next;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign w_mcand_abs  = (signed_mode && multicand[MULTICAND_WID-1])   ? ('0 - multicand)  : multicand;
  assign w_mplier_abs = (signed_mode && multiplier[MULTIPLIER_WID-1]) ? ('0 - multiplier) : multiplier;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_count == LAST_CNT);
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  cla_n #(
    .WIDTH(MULTICAND_WID)
  ) u_cla (
    .a   (r_acc[PROD_WID-1:MULTIPLIER_WID]),
    .b   (w_addend),
    .cin (1'b0),
    .sum (w_sum),
    .cout(w_cout)
  );

  assign w_acc_next = {w_cout, w_sum, r_acc[MULTIPLIER_WID-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= w_mcand_abs;
      r_mplier <= w_mplier_abs;
      r_neg    <= signed_mode & (multicand[MULTICAND_WID-1] ^ multiplier[MULTIPLIER_WID-1]);
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_next[PROD_WID-1:1];
      r_mplier <= {1'b0, r_mplier[MULTIPLIER_WID-1:1]};
      r_count  <= r_count + CNT_WID'(1);
      if (w_last) r_product <= r_neg ? ('0 - w_acc_next) : w_acc_next;
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier at 8x8 and 12x4.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv12, ir12, sm12, ov12, or12;
  logic [11:0] a12;
  logic [3:0]  b12;
  logic [15:0] p12;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.MULTICAND_WID(8), .MULTIPLIER_WID(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .multicand(a8),
    .multiplier(b8), .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  seq_multiplier #(.MULTICAND_WID(12), .MULTIPLIER_WID(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .multicand(a12),
    .multiplier(b12), .signed_mode(sm12), .out_valid(ov12), .out_ready(or12), .product(p12)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec8_t;

  vec8_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    a8  = a;
    b8  = b;
    sm8 = sm;
    iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
  endtask

  // Counts edges from accept to out_valid; flags any in_ready seen while busy.
  task automatic wait_done8(output int lat, output logic ready_seen);
    lat        = 0;
    ready_seen = (ir8 !== 1'b0);
    while (ov8 !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ir8 !== 1'b0) ready_seen = 1'b1;
    end
  endtask

  task automatic release8(input string name);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
    check({name, "_ovalid_drop"}, ov8, 1'b0);
    check({name, "_iready_back"}, ir8, 1'b1);
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input logic [15:0] exp);
    int   lat;
    logic rs;
    start8(a, b, sm);
    wait_done8(lat, rs);
    check({name, "_latency"}, lat, 8);
    check({name, "_busy_iready"}, rs, 1'b0);
    check({name, "_product"}, p8, exp);
    release8(name);
  endtask

  task automatic run12(input string name, input logic [11:0] a, input logic [3:0] b,
                       input logic sm, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    a12  = a;
    b12  = b;
    sm12 = sm;
    iv12 = 1'b1;
    @(posedge clk);
    #1;
    iv12 = 1'b0;
    lat  = 0;
    while (ov12 !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_product"}, p12, exp);
    // out_ready is held high, so the block is back in IDLE after one more edge.
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref12(input logic [11:0] a, input logic [3:0] b, input logic sm);
    logic signed [15:0] sa, sb;
    if (sm) begin
      sa = {{4{a[11]}}, a};
      sb = {{12{b[3]}}, b};
      return sa * sb;
    end
    return {4'b0, a} * {12'b0, b};
  endfunction

  initial begin
    int   lat;
    logic rs;
    logic [11:0] ra;
    logic [3:0]  rb;
    int unsigned rnd;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[4]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
    vecs[5]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[6]  = '{8'h80, 8'h02, 1'b1, 16'hFF00};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9]  = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
    vecs[10] = '{8'h0A, 8'h0B, 1'b0, 16'h006E};

    rst  = 1'b0;
    iv8  = 1'b0; sm8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0;
    iv12 = 1'b0; sm12 = 1'b0; or12 = 1'b0; a12 = '0; b12 = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_iready8", ir8, 1'b1);
    check("rst_ovalid8", ov8, 1'b0);
    check("rst_product8", p8, 16'h0000);
    check("rst_iready12", ir12, 1'b1);
    check("rst_ovalid12", ov12, 1'b0);
    check("rst_product12", p12, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);

    // Backpressure: result held while new operands are offered and must be ignored.
    start8(8'h0A, 8'h0B, 1'b0);
    wait_done8(lat, rs);
    check("bp_latency", lat, 8);
    check("bp_product", p8, 16'h006E);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a8  = 8'h03;
      b8  = 8'h03;
      sm8 = 1'b1;
      iv8 = (k % 2 == 0);
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_product%0d", k), p8, 16'h006E);
      check($sformatf("bp_hold_ovalid%0d", k), ov8, 1'b1);
      check($sformatf("bp_hold_iready%0d", k), ir8, 1'b0);
    end
    iv8 = 1'b0;
    release8("bp");
    run8("bp_next", 8'h07, 8'h06, 1'b0, 16'h002A);

    // Reset during RUN abandons the transaction without waiting for a clock edge.
    start8(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("midrst_busy_ovalid", ov8, 1'b0);
    check("midrst_old_product", p8, 16'h002A);
    rst = 1'b1;
    #1;
    check("midrst_ovalid", ov8, 1'b0);
    check("midrst_product", p8, 16'h0000);
    check("midrst_iready", ir8, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run8("after_rst", 8'h03, 8'h05, 1'b0, 16'h000F);

    or12 = 1'b1;
    run12("w12_min_min", 12'h800, 4'h8, 1'b1, 16'h4000);
    run12("w12_max_u", 12'hFFF, 4'hF, 1'b0, 16'hEFF1);
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 1000; n++) begin
        rnd = $urandom;
        ra  = rnd[11:0];
        rb  = rnd[15:12];
        run12($sformatf("w12_m%0d_%0d", mode, n), ra, rb, mode[0], ref12(ra, rb, mode[0]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
